dpram_fifo_ctrl: RTL and testbench

//   Show-ahead (first-word-fall-through) synchronous FIFO controller. It drives the write and

---
 rtl/dpram_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
//   Show-ahead (first-word-fall-through) FIFO controller wrapped around an
//   external dual-port RAM that has a one-cycle registered read. A two-entry
//   skid buffer in front of the RAM hides the read latency so the head word
//   is always presented combinationally on dout and one word per clock can
//   be popped.
//
// Ports
//   clk        : single clock, everything on its rising edge
//   reset_n    : synchronous, active-low reset
//   push, din  : write request and data; push is ignored while full=1
//   full       : total occupancy equals DEPTH+2
//   pop        : consume the head word; ignored while valid=0
//   dout       : head word, meaningful while valid=1
//   valid      : a head word is present
//   count      : total occupancy (RAM + read in flight + skid buffer)
//   ram_waddr  : RAM write address (write pointer)
//   ram_din    : RAM write data (din passed straight through)
//   ram_we     : RAM write enable (accepted push)
//   ram_raddr  : RAM read address (read pointer, driven every cycle)
//   ram_dout   : RAM read data, valid one clock after a read is issued

module dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic [ADDR_WIDTH+1:0] count,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] FULL_COUNT = (ADDR_WIDTH + 2)'(DEPTH + 2);

  // Registered state
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]   mem_cnt_reg, mem_cnt_next;
  logic                  rd_inflight_reg, rd_inflight_next;
  logic [1:0]            skid_cnt_reg, skid_cnt_next;
  logic [DATA_WIDTH-1:0] skid_data_reg  [0:1];
  logic [DATA_WIDTH-1:0] skid_data_next [0:1];

  // Handshake decode
  logic       wr_en;
  logic       rd_en;
  logic       pop_acc;
  logic [2:0] buf_occ_after_pop;
  logic [1:0] skid_cnt_after_pop;

  assign count = {1'b0, mem_cnt_reg}
               + (ADDR_WIDTH + 2)'(rd_inflight_reg)
               + (ADDR_WIDTH + 2)'(skid_cnt_reg);
  assign full  = (count == FULL_COUNT);
  assign valid = (skid_cnt_reg != 2'd0);
  assign dout  = skid_data_reg[0];

  assign pop_acc = pop & valid;
  // A reset cycle accepts nothing, so the RAM is never written while reset_n=0.
  assign wr_en   = push & ~full & reset_n;

  // Words already owned by the output side (skid + the read in flight) once
  // this cycle's pop is applied. A new read is only issued if its result is
  // guaranteed a skid slot when it lands next cycle.
  assign buf_occ_after_pop = {1'b0, skid_cnt_reg} + {2'b00, rd_inflight_reg}
                           - {2'b00, pop_acc};
  // mem_cnt_reg is the registered value, so a word becomes readable no
  // earlier than the cycle after its write; the read and write addresses of
  // live data therefore never collide in the same cycle.
  assign rd_en = (mem_cnt_reg != '0) && (buf_occ_after_pop < 3'd2);

  assign skid_cnt_after_pop = skid_cnt_reg - {1'b0, pop_acc};

  assign ram_waddr = wr_ptr_reg;
  assign ram_din   = din;
  assign ram_we    = wr_en;
  assign ram_raddr = rd_ptr_reg;

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_next      = wr_ptr_reg + ADDR_WIDTH'(wr_en);
    rd_ptr_next      = rd_ptr_reg + ADDR_WIDTH'(rd_en);
    mem_cnt_next     = mem_cnt_reg + (ADDR_WIDTH + 1)'(wr_en)
                                   - (ADDR_WIDTH + 1)'(rd_en);
    rd_inflight_next = rd_en;
    skid_cnt_next    = skid_cnt_after_pop + {1'b0, rd_inflight_reg};
  end

  // Skid buffer: slot 0 is the head. A pop shifts slot 1 forward first, then
  // a returning RAM word lands in the first free slot behind the new head.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      skid_data_next[i] = skid_data_reg[i];
    end
    if (pop_acc) begin
      skid_data_next[0] = skid_data_reg[1];
    end
    for (int i = 0; i < 2; i++) begin
      if (rd_inflight_reg && (skid_cnt_after_pop == 2'(i))) begin
        skid_data_next[i] = ram_dout;
      end
    end
  end

  // Reset clears rd_inflight too, so the RAM word returned in the cycle
  // after reset is never captured.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      mem_cnt_reg      <= '0;
      rd_inflight_reg  <= 1'b0;
      skid_cnt_reg     <= 2'd0;
      skid_data_reg[0] <= '0;
      skid_data_reg[1] <= '0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      mem_cnt_reg      <= mem_cnt_next;
      rd_inflight_reg  <= rd_inflight_next;
      skid_cnt_reg     <= skid_cnt_next;
      skid_data_reg[0] <= skid_data_next[0];
      skid_data_reg[1] <= skid_data_next[1];
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Testbench for dpram_fifo_ctrl. Contains a behavioural dual-port RAM, a
// queue-based reference model (each accepted word becomes visible at the
// head two edges after the edge that accepted it, once all older words are
// gone), a per-cycle compare process, and directed plus random stimulus.

module tb_dpram_fifo_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          reset_n;
  logic          push;
  logic [DW-1:0] din;
  logic          full;
  logic          pop;
  logic [DW-1:0] dout;
  logic          valid;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_dout;

  int total = 0;
  int bad   = 0;

  dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .din       (din),
    .full      (full),
    .pop       (pop),
    .dout      (dout),
    .valid     (valid),
    .count     (count),
    .ram_waddr (ram_waddr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_raddr (ram_raddr),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM with one-cycle registered read.
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_din;
    ram_dout <= ram_mem[ram_raddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mq[$];      // words held, oldest first
  longint        mr[$];      // edge count from which each word may be shown
  longint        edge_cnt = 0;
  logic [AW-1:0] m_wptr   = '0;
  bit            m_live   = 0;
  bit            m_pre_full, m_pre_valid;

  function automatic bit model_valid();
    return (mq.size() != 0) && (edge_cnt >= mr[0]);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        mq.delete();
        mr.delete();
        m_wptr = '0;
        m_live = 1;
      end else if (m_live) begin
        m_pre_full  = (mq.size() == DEPTH + 2);
        m_pre_valid = model_valid();
        if (pop && m_pre_valid) begin
          void'(mq.pop_front());
          void'(mr.pop_front());
        end
        if (push && !m_pre_full) begin
          mq.push_back(din);
          // accepted at edge number edge_cnt; head-visible two edges later
          mr.push_back(edge_cnt + 3);
          m_wptr = m_wptr + 1'b1;
        end
      end
      edge_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("count", count, mq.size());
        chk("valid", valid, model_valid());
        chk("full", full, mq.size() == DEPTH + 2);
        if (model_valid()) chk("dout", dout, mq[0]);
        chk("ram_waddr", ram_waddr, m_wptr);
        chk("ram_we", ram_we, push && reset_n && (mq.size() != DEPTH + 2));
        chk("ram_din", ram_din, din);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    push    = 1'b1;
    pop     = 1'b0;
    din     = 32'h1111_2222;

    // 1: reset held 3 clocks with push asserted
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_count", count, 0);
      chk("rst_valid", valid, 0);
      chk("rst_full", full, 0);
      chk("rst_we", ram_we, 0);
    end
    reset_n = 1'b1;
    push    = 1'b0;
    $display("reset: count=%0d valid=%0b full=%0b", count, valid, full);

    // 2: latency into an empty FIFO
    push = 1'b1;
    din  = 32'hA5A5_0001;
    step();
    push = 1'b0;
    chk("lat_c0_valid", valid, 0);
    chk("lat_c0_count", count, 1);
    step();
    chk("lat_c1_valid", valid, 0);
    step();
    chk("lat_c2_valid", valid, 1);
    chk("lat_c2_dout", dout, 32'hA5A5_0001);
    chk("lat_c2_count", count, 1);
    $display("latency: valid=%0b dout=%h", valid, dout);

    // 3: fill with 40 words, 34 accepted, then drain in order
    do_reset(1);
    for (int k = 0; k < 40; k++) begin
      push = 1'b1;
      din  = 32'(k);
      step();
      if (k == 32) chk("fill_not_full_32", full, 0);
      if (k == 33) begin
        chk("fill_full_33", full, 1);
        chk("fill_count_33", count, DEPTH + 2);
      end
    end
    push = 1'b0;
    chk("fill_count_end", count, DEPTH + 2);
    for (int i = 0; i < DEPTH + 2; i++) begin
      chk("drain_valid", valid, 1);
      chk("drain_dout", dout, 32'(i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    chk("drain_empty_valid", valid, 0);
    chk("drain_empty_count", count, 0);
    $display("fill/drain: last count=%0d", count);

    // 5a: pop while empty changes nothing
    pop = 1'b1;
    repeat (3) begin
      step();
      chk("empty_pop_count", count, 0);
      chk("empty_pop_valid", valid, 0);
    end
    pop = 1'b0;

    // 5b: full + push + pop -> only the pop is taken
    for (int k = 0; k < DEPTH + 2; k++) begin
      push = 1'b1;
      din  = 32'(100 + k);
      step();
    end
    push = 1'b0;
    step();
    step();
    chk("edge_full", full, 1);
    push = 1'b1;
    din  = 32'hDEAD_BEEF;
    pop  = 1'b1;
    #1;
    chk("edge_we_blocked", ram_we, 0);
    step();
    push = 1'b0;
    pop  = 1'b0;
    chk("edge_count", count, DEPTH + 1);
    chk("edge_not_full", full, 0);
    chk("edge_next_head", dout, 32'd101);
    $display("full push+pop: count=%0d", count);

    // 4: streaming push+pop, 100 words through a wrapping RAM
    do_reset(1);
    for (int i = 0; i <= 102; i++) begin
      push = (i < 100);
      din  = 32'(1000 + i);
      pop  = 1'b1;
      step();
      if (i >= 2 && i <= 101) begin
        chk("stream_valid", valid, 1);
        chk("stream_dout", dout, 32'(1000 + i - 2));
      end
      if (i == 102) chk("stream_end_valid", valid, 0);
    end
    pop = 1'b0;
    $display("stream: 100 words, final count=%0d", count);

    // 6: reset mid-stream with a read in flight
    for (int i = 0; i < 10; i++) begin
      push = 1'b1;
      din  = 32'(32'h5000 + i);
      pop  = 1'b1;
      step();
    end
    reset_n = 1'b0;
    push    = 1'b1;
    din     = 32'h0BAD_0BAD;
    pop     = 1'b0;
    step();
    chk("midrst_count", count, 0);
    chk("midrst_valid", valid, 0);
    reset_n = 1'b1;
    push    = 1'b1;
    din     = 32'h1234_5678;
    step();
    push = 1'b0;
    chk("midrst_c0_valid", valid, 0);
    step();
    chk("midrst_c1_valid", valid, 0);
    step();
    chk("midrst_c2_valid", valid, 1);
    chk("midrst_c2_dout", dout, 32'h1234_5678);
    chk("midrst_c2_count", count, 1);
    $display("mid reset: dout=%h", dout);

    // Random traffic with varying push/pop pressure and rare resets
    for (int seg = 0; seg < 20; seg++) begin
      int push_pct;
      int pop_pct;
      push_pct = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 50 : 15);
      pop_pct  = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        reset_n = ($urandom_range(0, 499) != 0);
        push    = ($urandom_range(0, 99) < push_pct);
        pop     = ($urandom_range(0, 99) < pop_pct);
        din     = $urandom;
        step();
      end
      $display("random segment %0d: push%%=%0d pop%%=%0d count=%0d", seg, push_pct, pop_pct, count);
    end
    push    = 1'b0;
    pop     = 1'b0;
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
